wt_mem_req_arbiter: RTL and testbench

- Shares the single memory request port between the instruction cache (requester 0) and the write-through data cache (requester 1).
- Round-robin arbitration with a one-entry registered output stage.
- Prepends a requester bit to each transaction ID and routes responses back by that bit.
- Tracks in-flight transactions per requester, caps them at MaxOutstanding, and reports when the dcache still has stores outstanding (used for fence/AMO drain).

---
 rtl/wt_mem_req_arbiter.sv | 178 +++++++++++++++++
 tb/tb_wt_mem_req_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_mem_req_arbiter.sv
// wt_mem_req_arbiter: shares one memory request port between the icache (requester 0)
// and the write-through dcache (requester 1). It arbitrates round-robin into a
// one-entry registered output stage and tags each ID with the requester bit.
// Responses are routed back by that bit. Per-requester in-flight counts are
// capped, and outstanding dcache stores are tracked for fence/AMO drain.
module wt_mem_req_arbiter #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned MaxOutstanding = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // icache request
  input  logic                   ic_req_valid_i,
  output logic                   ic_req_ready_o,
  input  logic [AddrWidth-1:0]   ic_req_addr_i,
  input  logic [TidWidth-1:0]    ic_req_tid_i,
  // dcache request
  input  logic                   dc_req_valid_i,
  output logic                   dc_req_ready_o,
  input  logic [AddrWidth-1:0]   dc_req_addr_i,
  input  logic                   dc_req_we_i,
  input  logic [DataWidth-1:0]   dc_req_wdata_i,
  input  logic [DataWidth/8-1:0] dc_req_be_i,
  input  logic [TidWidth-1:0]    dc_req_tid_i,
  // memory request
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [AddrWidth-1:0]   mem_req_addr_o,
  output logic                   mem_req_we_o,
  output logic [DataWidth-1:0]   mem_req_wdata_o,
  output logic [DataWidth/8-1:0] mem_req_be_o,
  output logic [TidWidth:0]      mem_req_id_o,
  // memory response
  input  logic                   mem_rsp_valid_i,
  input  logic [TidWidth:0]      mem_rsp_id_i,
  input  logic [DataWidth-1:0]   mem_rsp_rdata_i,
  // routed responses
  output logic                   ic_rsp_valid_o,
  output logic [TidWidth-1:0]    ic_rsp_tid_o,
  output logic [DataWidth-1:0]   ic_rsp_rdata_o,
  output logic                   dc_rsp_valid_o,
  output logic [TidWidth-1:0]    dc_rsp_tid_o,
  output logic [DataWidth-1:0]   dc_rsp_rdata_o,
  // status
  output logic                   dc_store_pending_o,
  output logic                   idle_o
);

  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeW    = DataWidth / 8;
  localparam int unsigned NumTid = 1 << TidWidth;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  // output stage
  logic                 r_valid;
  logic [AddrWidth-1:0] r_addr;
  logic                 r_we;
  logic [DataWidth-1:0] r_wdata;
  logic [BeW-1:0]       r_be;
  logic [TidWidth:0]    r_id;
  logic                 r_last;   // last granted requester (1 = dcache)

  // bookkeeping, index 0 = icache, 1 = dcache
  logic [1:0][CntW-1:0] r_cnt;
  logic [1:0][CntW-1:0] w_cnt_nxt;
  logic [CntW-1:0]      r_st_cnt;
  logic [NumTid-1:0]    r_wmask;
  logic                 r_idle;

  logic       w_free, w_gnt_dc, w_valid_nxt, w_wr_iss, w_wr_rsp;
  logic [1:0] w_elig, w_acc, w_rsp, w_dec;

  assign w_free    = !r_valid || mem_req_ready_i;
  assign w_elig[0] = ic_req_valid_i && (r_cnt[0] < MaxCnt);
  assign w_elig[1] = dc_req_valid_i && (r_cnt[1] < MaxCnt);
  // on a tie the requester that did not win last time gets the slot
  assign w_gnt_dc  = w_elig[1] && (!w_elig[0] || !r_last);

  assign ic_req_ready_o = w_free && w_elig[0] && !w_gnt_dc;
  assign dc_req_ready_o = w_free && w_gnt_dc;
  assign w_acc          = {dc_req_ready_o, ic_req_ready_o};

  assign w_valid_nxt = (|w_acc) ? 1'b1 : (w_free ? 1'b0 : r_valid);

  // response routing is purely combinational
  assign w_rsp[0]       = mem_rsp_valid_i && !mem_rsp_id_i[TidWidth];
  assign w_rsp[1]       = mem_rsp_valid_i &&  mem_rsp_id_i[TidWidth];
  assign ic_rsp_valid_o = w_rsp[0];
  assign dc_rsp_valid_o = w_rsp[1];
  assign ic_rsp_tid_o   = mem_rsp_id_i[TidWidth-1:0];
  assign dc_rsp_tid_o   = mem_rsp_id_i[TidWidth-1:0];
  assign ic_rsp_rdata_o = mem_rsp_rdata_i;
  assign dc_rsp_rdata_o = mem_rsp_rdata_i;

  assign w_wr_iss = w_acc[1] && dc_req_we_i;
  assign w_wr_rsp = w_rsp[1] && r_wmask[mem_rsp_id_i[TidWidth-1:0]];

  assign mem_req_valid_o    = r_valid;
  assign mem_req_addr_o     = r_addr;
  assign mem_req_we_o       = r_we;
  assign mem_req_wdata_o    = r_wdata;
  assign mem_req_be_o       = r_be;
  assign mem_req_id_o       = r_id;
  assign dc_store_pending_o = |r_wmask;
  assign idle_o             = r_idle;

  // next in-flight count per requester; a response at zero is ignored
  always_comb begin
    w_dec     = '0;
    w_cnt_nxt = r_cnt;
    for (int r = 0; r < 2; r++) begin
      w_dec[r] = w_rsp[r] && (r_cnt[r] != '0);
      if (w_acc[r] && !w_dec[r])      w_cnt_nxt[r] = r_cnt[r] + 1'b1;
      else if (!w_acc[r] && w_dec[r]) w_cnt_nxt[r] = r_cnt[r] - 1'b1;
    end
  end

  // output stage: load on accept, drop when drained, hold under back-pressure
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_id    <= '0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_acc[1]) begin
        r_addr  <= dc_req_addr_i;
        r_we    <= dc_req_we_i;
        r_wdata <= dc_req_wdata_i;
        r_be    <= dc_req_be_i;
        r_id    <= {1'b1, dc_req_tid_i};
        r_last  <= 1'b1;
      end else if (w_acc[0]) begin
        r_addr  <= ic_req_addr_i;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_be    <= '1;
        r_id    <= {1'b0, ic_req_tid_i};
        r_last  <= 1'b0;
      end
    end
  end

  // in-flight counters and idle flag (idle reflects the state being loaded)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_idle <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_idle <= !w_valid_nxt && (w_cnt_nxt[0] == '0) && (w_cnt_nxt[1] == '0);
    end
  end

  // store tracking: write-tid mask plus count; a new issue wins over a same-tid clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wmask  <= '0;
      r_st_cnt <= '0;
    end else begin
      if (w_wr_rsp) r_wmask[mem_rsp_id_i[TidWidth-1:0]] <= 1'b0;
      if (w_wr_iss) r_wmask[dc_req_tid_i] <= 1'b1;
      if (w_wr_iss && !w_wr_rsp)      r_st_cnt <= r_st_cnt + 1'b1;
      else if (!w_wr_iss && w_wr_rsp) r_st_cnt <= r_st_cnt - 1'b1;
    end
  end

  // a response for a requester with nothing in flight is a protocol error
  a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rsp_valid_i |-> (mem_rsp_id_i[TidWidth] ? (r_cnt[1] != '0) : (r_cnt[0] != '0)));

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Bench for wt_mem_req_arbiter: a vector table for the arbitration order, directed
// corner sequences, and a randomized run checked against a transaction-level model.
module tb_wt_mem_req_arbiter;
  localparam int AW = 64, DW = 64, TW = 2, MO = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ic_v, ic_rdy, dc_v, dc_rdy, dc_we, mv, mrdy, mwe, rsp_v;
  logic [AW-1:0] ic_addr, dc_addr, maddr;
  logic [TW-1:0] ic_tid, dc_tid, ic_rtid, dc_rtid;
  logic [DW-1:0] dc_wdata, mwdata, rsp_rdata, ic_rdata, dc_rdata;
  logic [7:0]    dc_be, mbe;
  logic [TW:0]   mid, rsp_id;
  logic          ic_rv, dc_rv, pend, idle;

  wt_mem_req_arbiter #(.AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ic_req_valid_i(ic_v), .ic_req_ready_o(ic_rdy), .ic_req_addr_i(ic_addr), .ic_req_tid_i(ic_tid),
    .dc_req_valid_i(dc_v), .dc_req_ready_o(dc_rdy), .dc_req_addr_i(dc_addr), .dc_req_we_i(dc_we),
    .dc_req_wdata_i(dc_wdata), .dc_req_be_i(dc_be), .dc_req_tid_i(dc_tid),
    .mem_req_valid_o(mv), .mem_req_ready_i(mrdy), .mem_req_addr_o(maddr), .mem_req_we_o(mwe),
    .mem_req_wdata_o(mwdata), .mem_req_be_o(mbe), .mem_req_id_o(mid),
    .mem_rsp_valid_i(rsp_v), .mem_rsp_id_i(rsp_id), .mem_rsp_rdata_i(rsp_rdata),
    .ic_rsp_valid_o(ic_rv), .ic_rsp_tid_o(ic_rtid), .ic_rsp_rdata_o(ic_rdata),
    .dc_rsp_valid_o(dc_rv), .dc_rsp_tid_o(dc_rtid), .dc_rsp_rdata_o(dc_rdata),
    .dc_store_pending_o(pend), .idle_o(idle)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // transaction-level model: what sits in the output slot, what is in flight
  bit          m_valid, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;
  logic [2:0]  m_id;
  int          m_last;          // requester that won the previous grant
  bit          m_wr[4];         // tids with a store in flight
  logic [1:0]  q_out[2][$];     // in-flight tids per requester

  function automatic bit any_wr();
    return m_wr[0] | m_wr[1] | m_wr[2] | m_wr[3];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_id = '0; m_last = 0;
    for (int i = 0; i < 4; i++) m_wr[i] = 0;
    q_out[0].delete();
    q_out[1].delete();
  endtask

  task automatic idle_inputs();
    ic_v = 0; dc_v = 0; dc_we = 0; mrdy = 1; rsp_v = 0; rsp_id = '0; rsp_rdata = '0;
    ic_addr = '0; ic_tid = '0; dc_addr = '0; dc_tid = '0; dc_wdata = '0; dc_be = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // one clock: inputs were driven at the preceding negedge; ends at the next negedge
  task automatic step();
    bit free, e_ic, e_dc, g_dc, a_ic, a_dc;
    int r, n;
    logic [1:0] t;
    #1;
    n    = q_out[0].size();
    e_ic = ic_v && (n < MO);
    e_dc = dc_v && (q_out[1].size() < MO);
    free = !m_valid || mrdy;
    g_dc = (e_ic && e_dc) ? (m_last == 0) : e_dc;
    a_dc = free && g_dc;
    a_ic = free && e_ic && !g_dc;
    chk("ic_ready", 64'(ic_rdy), 64'(a_ic));
    chk("dc_ready", 64'(dc_rdy), 64'(a_dc));
    chk("ic_rsp_valid", 64'(ic_rv), 64'(rsp_v && !rsp_id[2]));
    chk("dc_rsp_valid", 64'(dc_rv), 64'(rsp_v && rsp_id[2]));
    if (rsp_v) begin
      r = int'(rsp_id[2]);
      t = rsp_id[1:0];
      chk("rsp_tid", 64'(r ? dc_rtid : ic_rtid), 64'(t));
      chk("rsp_rdata", r ? dc_rdata : ic_rdata, rsp_rdata);
      for (int i = 0; i < q_out[r].size(); i++)
        if (q_out[r][i] == t) begin q_out[r].delete(i); break; end
      if (r == 1) m_wr[t] = 0;
    end
    if (a_dc) begin
      m_valid = 1; m_addr = dc_addr; m_we = dc_we; m_wdata = dc_wdata; m_be = dc_be;
      m_id = {1'b1, dc_tid}; m_last = 1; q_out[1].push_back(dc_tid);
      if (dc_we) m_wr[dc_tid] = 1;
    end else if (a_ic) begin
      m_valid = 1; m_addr = ic_addr; m_we = 0; m_wdata = '0; m_be = 8'hFF;
      m_id = {1'b0, ic_tid}; m_last = 0; q_out[0].push_back(ic_tid);
    end else if (free) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("mem_valid", 64'(mv), 64'(m_valid));
    if (m_valid) begin
      chk("mem_addr", maddr, m_addr);
      chk("mem_we", 64'(mwe), 64'(m_we));
      chk("mem_wdata", mwdata, m_wdata);
      chk("mem_be", 64'(mbe), 64'(m_be));
      chk("mem_id", 64'(mid), 64'(m_id));
    end
    chk("store_pending", 64'(pend), 64'(any_wr()));
    chk("idle", 64'(idle), 64'(!m_valid && q_out[0].size() == 0 && q_out[1].size() == 0));
    @(negedge clk);
  endtask

  typedef struct {
    bit ic_v;
    bit dc_v;
    bit exp_ic_rdy;
    bit exp_dc_rdy;
    bit exp_msb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit ok_dc[4];
    int nfree, pick, r;
    logic [1:0] ftid[$];

    // -------- reset state
    do_reset();
    chk("rst_valid", 64'(mv), 64'd0);
    chk("rst_addr", maddr, 64'd0);
    chk("rst_id", 64'(mid), 64'd0);
    chk("rst_be", 64'(mbe), 64'd0);
    chk("rst_wdata", mwdata, 64'd0);
    chk("rst_we", 64'(mwe), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_pending", 64'(pend), 64'd0);
    chk("rst_rsp", 64'({ic_rv, dc_rv}), 64'd0);
    dc_v = 1; dc_addr = 64'h100; dc_tid = 2'd0;
    #1 chk("lone_dc_ready", 64'(dc_rdy), 64'd1);
    step();
    dc_v = 0; ic_v = 1; ic_addr = 64'h200; ic_tid = 2'd0;
    #1 chk("lone_ic_ready", 64'(ic_rdy), 64'd1);
    step();

    // -------- arbitration order from reset, full throughput
    tbl[0] = '{1, 1, 0, 1, 1};
    tbl[1] = '{1, 1, 1, 0, 0};
    tbl[2] = '{1, 1, 0, 1, 1};
    tbl[3] = '{1, 1, 1, 0, 0};
    tbl[4] = '{1, 0, 1, 0, 0};
    tbl[5] = '{1, 1, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ic_v = tbl[i].ic_v; dc_v = tbl[i].dc_v; mrdy = 1; dc_we = 0;
      ic_addr = 64'h1000 + 64'(i * 8); ic_tid = 2'(i);
      dc_addr = 64'h2000 + 64'(i * 8); dc_tid = 2'(i);
      #1;
      chk("tbl_ic_ready", 64'(ic_rdy), 64'(tbl[i].exp_ic_rdy));
      chk("tbl_dc_ready", 64'(dc_rdy), 64'(tbl[i].exp_dc_rdy));
      step();
      chk("tbl_mem_valid", 64'(mv), 64'd1);
      chk("tbl_id_msb", 64'(mid[2]), 64'(tbl[i].exp_msb));
    end

    // -------- back-pressure holds a dcache store
    do_reset();
    dc_v = 1; dc_we = 1; dc_addr = 64'h8000_0040; dc_be = 8'h0F;
    dc_wdata = 64'h1122_3344_5566_7788; dc_tid = 2'd1; mrdy = 0;
    step();
    chk("bp_loaded", 64'(mv), 64'd1);
    dc_we = 0; dc_addr = 64'h9000; dc_tid = 2'd3; ic_v = 1; ic_addr = 64'hA000;
    repeat (5) begin
      #1;
      chk("bp_ic_ready", 64'(ic_rdy), 64'd0);
      chk("bp_dc_ready", 64'(dc_rdy), 64'd0);
      step();
      chk("bp_addr", maddr, 64'h8000_0040);
      chk("bp_be", 64'(mbe), 64'h0F);
      chk("bp_id", 64'(mid), 64'b101);
    end
    ic_v = 0; dc_v = 0; mrdy = 1;
    step();
    chk("bp_drained", 64'(mv), 64'd0);

    // -------- outstanding cap on the icache
    do_reset();
    ic_v = 1;
    for (int i = 0; i < MO; i++) begin
      ic_tid = 2'(i); ic_addr = 64'h4000 + 64'(i * 64);
      step();
    end
    dc_v = 1; dc_we = 0; dc_tid = 2'd0; dc_addr = 64'h5000;
    #1;
    chk("cap_ic_blocked", 64'(ic_rdy), 64'd0);
    chk("cap_dc_accepted", 64'(dc_rdy), 64'd1);
    step();
    dc_v = 0; rsp_v = 1; rsp_id = 3'b001; rsp_rdata = 64'hCAFE_0001;
    #1;
    chk("cap_still_blocked", 64'(ic_rdy), 64'd0);
    chk("cap_ic_rsp", 64'(ic_rv), 64'd1);
    chk("cap_ic_rsp_tid", 64'(ic_rtid), 64'd1);
    step();
    rsp_v = 0;
    #1 chk("cap_reopened", 64'(ic_rdy), 64'd1);
    step();

    // -------- store drain
    do_reset();
    ic_v = 1; ic_tid = 2'd3; ic_addr = 64'h6000;
    step();
    ic_v = 0; dc_v = 1; dc_we = 1; dc_tid = 2'd2; dc_addr = 64'h7000;
    dc_wdata = 64'h55; dc_be = 8'hF0;
    step();
    chk("drain_pending_set", 64'(pend), 64'd1);
    dc_v = 0; rsp_v = 1; rsp_id = 3'b110; rsp_rdata = 64'hBEEF_0002;
    #1;
    chk("drain_dc_rsp", 64'(dc_rv), 64'd1);
    chk("drain_dc_tid", 64'(dc_rtid), 64'd2);
    chk("drain_dc_rdata", dc_rdata, 64'hBEEF_0002);
    chk("drain_no_ic_rsp", 64'(ic_rv), 64'd0);
    step();
    chk("drain_pending_clr", 64'(pend), 64'd0);
    rsp_id = 3'b011; rsp_rdata = 64'hD00D_0003;
    #1;
    chk("drain_ic_rsp", 64'(ic_rv), 64'd1);
    chk("drain_ic_not_dc", 64'(dc_rv), 64'd0);
    chk("drain_ic_tid", 64'(ic_rtid), 64'd3);
    step();
    rsp_v = 0;

    // -------- async reset with requests in flight and the output stage full
    do_reset();
    ic_v = 1; ic_tid = 2'd0; ic_addr = 64'h10;
    step();
    ic_v = 0; dc_v = 1; dc_we = 1; dc_tid = 2'd1; dc_addr = 64'h20; dc_be = 8'hFF;
    step();
    dc_v = 0; ic_v = 1; ic_tid = 2'd2; ic_addr = 64'h30;
    step();
    ic_v = 0; mrdy = 0;
    chk("ar_full", 64'(mv), 64'd1);
    chk("ar_pending_before", 64'(pend), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("ar_valid", 64'(mv), 64'd0);
    chk("ar_addr", maddr, 64'd0);
    chk("ar_id", 64'(mid), 64'd0);
    chk("ar_pending", 64'(pend), 64'd0);
    chk("ar_idle", 64'(idle), 64'd1);
    chk("ar_rsp", 64'({ic_rv, dc_rv}), 64'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    ic_v = 1; dc_v = 1; dc_tid = 2'd0;
    #1 chk("ar_dc_wins_tie", 64'(dc_rdy), 64'd1);
    step();

    // -------- randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ic_v = ($urandom_range(0, 3) != 0);
      ic_tid = 2'($urandom_range(0, 3));
      ic_addr = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) ok_dc[i] = 1;
      foreach (q_out[1][i]) ok_dc[q_out[1][i]] = 0;
      ftid.delete();
      for (int i = 0; i < 4; i++) if (ok_dc[i]) ftid.push_back(2'(i));
      nfree = ftid.size();
      dc_v = (nfree > 0) && ($urandom_range(0, 1) != 0);
      dc_tid = (nfree > 0) ? ftid[$urandom_range(0, nfree - 1)] : 2'd0;
      dc_we = ($urandom_range(0, 1) != 0);
      dc_addr = {$urandom, $urandom};
      dc_wdata = {$urandom, $urandom};
      dc_be = 8'($urandom);
      mrdy = ($urandom_range(0, 3) != 0);
      rsp_v = 0;
      if ($urandom_range(0, 2) == 0 && (q_out[0].size() + q_out[1].size()) > 0) begin
        if (q_out[0].size() == 0) r = 1;
        else if (q_out[1].size() == 0) r = 0;
        else r = int'($urandom_range(0, 1));
        pick = int'($urandom_range(0, q_out[r].size() - 1));
        rsp_v = 1;
        rsp_id = {r[0], q_out[r][pick]};
        rsp_rdata = {$urandom, $urandom};
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
